jump_input_ctrl: RTL and testbench

//   Conditions the raw up/down push-buttons and produces the frame-aligned io_jump

---
 rtl/jump_input_ctrl.sv | 147 ++++++++++++++
 tb/tb_jump_input_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jump_input_ctrl.sv
// Purpose: synchronise and debounce the up/down buttons, turn each up-press into one frame-aligned io_jump.
// Latency: raw edge -> *_clean in DEBOUNCE_CYCLES+2 edges; io_jump rises the cycle after the screen_end that accepts it.
// Backpressure: none; inputs are sampled every cycle, and a press arriving while a jump is pending is dropped.
module jump_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int HOLD_FRAMES     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       screen_end,
    output logic       io_jump,
    output logic       up_clean,
    output logic       down_clean,
    output logic [7:0] jump_count
);

    // fc must hold values 0..HOLD_FRAMES-1; never narrower than one bit
    localparam int FC_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(HOLD_FRAMES - 1);
    localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    // Bit 0 carries the up button, bit 1 the down button throughout.
    logic [1:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       clean_q, clean_d;
    logic             up_prev_q;
    logic             up_rise;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             io_jump_q, io_jump_d;
    logic [7:0]       jump_count_q, jump_count_d;

    // Two-flop synchroniser for both asynchronous buttons
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {down, up};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive disagreeing cycles, accept the new level on the last one
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]   = '0;
            clean_d[i] = clean_q[i];
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Debounce state and the delayed copy of up_clean used for press detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            clean_q   <= 2'b00;
            up_prev_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            clean_q   <= clean_d;
            up_prev_q <= clean_q[0];
        end
    end

    assign up_rise = clean_q[0] & ~up_prev_q;

    // Jump FSM: accept a press in IDLE, wait for the frame boundary, hold for HOLD_FRAMES frames
    always_comb begin
        state_d      = state_q;
        fc_d         = fc_q;
        io_jump_d    = io_jump_q;
        jump_count_d = jump_count_q;
        case (state_q)
            IDLE: begin
                // A coincident screen_end is deliberately not consumed here
                if (up_rise && !clean_q[1]) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (screen_end) begin
                    state_d      = ACTIVE;
                    io_jump_d    = 1'b1;
                    fc_d         = '0;
                    jump_count_d = jump_count_q + 8'd1;
                end
            end
            ACTIVE: begin
                if (screen_end) begin
                    if (fc_q == FC_LAST) begin
                        state_d   = IDLE;
                        io_jump_d = 1'b0;
                        fc_d      = '0;
                    end else begin
                        fc_d = fc_q + FC_ONE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                io_jump_d = 1'b0;
                fc_d      = '0;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fc_q         <= '0;
            io_jump_q    <= 1'b0;
            jump_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            fc_q         <= fc_d;
            io_jump_q    <= io_jump_d;
            jump_count_q <= jump_count_d;
        end
    end

    assign io_jump    = io_jump_q;
    assign up_clean   = clean_q[0];
    assign down_clean = clean_q[1];
    assign jump_count = jump_count_q;

endmodule

// File: tb/tb_jump_input_ctrl.sv
// Bench for jump_input_ctrl: two instances (HOLD_FRAMES=1 and 3) share stimulus and are
// compared every cycle against a window-based debounce model and a pending/active jump model.
module tb_jump_input_ctrl;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       screen_end = 1'b0;
    logic       j0, uc0, dc0, j1, uc1, dc1;
    logic [7:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    jump_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .HOLD_FRAMES(1)) u_dut0 (
        .clock(clock), .reset(reset), .up(up), .down(down), .screen_end(screen_end),
        .io_jump(j0), .up_clean(uc0), .down_clean(dc0), .jump_count(cnt0)
    );

    jump_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .HOLD_FRAMES(3)) u_dut1 (
        .clock(clock), .reset(reset), .up(up), .down(down), .screen_end(screen_end),
        .io_jump(j1), .up_clean(uc1), .down_clean(dc1), .jump_count(cnt1)
    );

    always #5 clock = ~clock;

    // Reference model state
    bit hu[$];
    bit hd[$];
    bit m_uc, m_dc, m_uc_prev;
    int pend[2], act[2], left_fr[2], mcnt[2];
    int hold[2] = '{1, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        hu.delete();
        hd.delete();
        for (int k = 0; k < DEB + 2; k++) begin
            hu.push_front(1'b0);
            hd.push_front(1'b0);
        end
        m_uc = 0; m_dc = 0; m_uc_prev = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; act[i] = 0; left_fr[i] = 0; mcnt[i] = 0;
        end
    endtask

    // Synchronised sample seen at an edge is the raw level from two edges earlier;
    // the clean level follows once DEB consecutive such samples agree on a new value.
    function automatic bit settle(input bit q[$], input bit cur);
        bit v = q[2];
        for (int k = 2; k <= DEB + 1; k++) begin
            if (q[k] != v) return cur;
        end
        return v;
    endfunction

    task automatic model_edge();
        bit rise;
        if (reset) begin
            model_reset();
            return;
        end
        rise = m_uc & ~m_uc_prev;
        for (int i = 0; i < 2; i++) begin
            if (act[i] != 0) begin
                if (screen_end) begin
                    left_fr[i]--;
                    if (left_fr[i] == 0) act[i] = 0;
                end
            end else if (pend[i] != 0) begin
                if (screen_end) begin
                    pend[i] = 0;
                    act[i] = 1;
                    left_fr[i] = hold[i];
                    mcnt[i] = (mcnt[i] + 1) % 256;
                end
            end else if (rise && !m_dc) begin
                pend[i] = 1;
            end
        end
        m_uc_prev = m_uc;
        hu.push_front(up);
        void'(hu.pop_back());
        hd.push_front(down);
        void'(hd.pop_back());
        m_uc = settle(hu, m_uc);
        m_dc = settle(hd, m_dc);
    endtask

    task automatic check_all();
        chk("up_clean0", 32'(uc0), 32'(m_uc));
        chk("down_clean0", 32'(dc0), 32'(m_dc));
        chk("io_jump0", 32'(j0), 32'(act[0]));
        chk("jump_count0", 32'(cnt0), 32'(mcnt[0]));
        chk("up_clean1", 32'(uc1), 32'(m_uc));
        chk("down_clean1", 32'(dc1), 32'(m_dc));
        chk("io_jump1", 32'(j1), 32'(act[1]));
        chk("jump_count1", 32'(cnt1), 32'(mcnt[1]));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic pulse_se();
        screen_end = 1'b1;
        tick();
        screen_end = 1'b0;
    endtask

    initial begin
        int up_hold, dn_hold;
        model_reset();

        // Reset held with both buttons pressed, then released
        up = 1'b1; down = 1'b1; reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        repeat (8) tick();
        up = 1'b0; down = 1'b0;
        repeat (8) tick();

        // Clean press, jump on a later frame, ended by the next frame
        up = 1'b1;
        repeat (10) tick();
        pulse_se();
        repeat (5) tick();
        pulse_se();
        repeat (4) tick();
        up = 1'b0;
        repeat (8) tick();

        // Bouncy up that never settles long enough
        for (int c = 0; c < 30; c++) begin
            up = ((c / 2) % 2) != 0;
            tick();
        end
        up = 1'b0;
        repeat (8) tick();

        // Press, jump, second press while ACTIVE, release
        up = 1'b1; repeat (7) tick();
        pulse_se();
        up = 1'b0; repeat (6) tick();
        up = 1'b1; repeat (7) tick();
        up = 1'b0; repeat (6) tick();
        repeat (3) pulse_se();
        repeat (3) tick();

        // screen_end coincident with up_rise in IDLE
        up = 1'b1;
        repeat (6) tick();
        pulse_se();
        repeat (4) tick();
        pulse_se();
        up = 1'b0;
        repeat (4) pulse_se();
        repeat (4) tick();

        // Press while ducking is dropped
        down = 1'b1; repeat (8) tick();
        up = 1'b1; repeat (8) tick();
        pulse_se();
        repeat (3) tick();
        up = 1'b0; down = 1'b0;
        repeat (8) tick();

        // Randomized stretches of bouncy and held buttons with random frame pulses
        up_hold = 0; dn_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (up_hold == 0) begin
                up = 1'($urandom);
                up_hold = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 14);
            end
            if (dn_hold == 0) begin
                down = ($urandom_range(0, 3) == 0);
                dn_hold = $urandom_range(1, 30);
            end
            screen_end = ($urandom_range(0, 9) == 0);
            up_hold--; dn_hold--;
            tick();
        end
        up = 1'b0; down = 1'b0; screen_end = 1'b0;
        repeat (12) tick();
        repeat (4) pulse_se();

        // 256 press/frame cycles so jump_count wraps
        for (int n = 0; n < 256; n++) begin
            up = 1'b1; repeat (7) tick();
            up = 1'b0; repeat (7) tick();
            pulse_se();
            tick();
            pulse_se();
            tick();
        end
        repeat (4) pulse_se();

        // Enter ACTIVE, then assert reset mid-cycle
        up = 1'b1; repeat (8) tick();
        pulse_se();
        chk("active_before_reset", 32'(j0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_io_jump0", 32'(j0), 32'd0);
        chk("async_count0", 32'(cnt0), 32'd0);
        chk("async_io_jump1", 32'(j1), 32'd0);
        chk("async_count1", 32'(cnt1), 32'd0);
        chk("async_up_clean", 32'(uc0), 32'd0);
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
